fifo_uart_tx: RTL and testbench
===============================

# fifo_uart_tx

Serial transmit stage that drains bytes from the synchronous FIFO's read port and shifts them out as 8N1-style UART frames (start bit, DATA_WIDTH data bits LSB first, one stop bit). It sits directly downstream of the FIFO: it owns the FIFO's read enable, consumes its registered read data, and drives the board-level TX line.

## Interface
- DATA_WIDTH, 8, data bits per frame; equals FIFO word width.
- CLKS_PER_BIT, 868, clk cycles per serial bit (100 MHz / 115200); legal range ≥ 2.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  transmit enable; low holds the block in IDLE, never aborts a frame in flight.
- fifo_empty  in  1  FIFO empty flag.
- fifo_dout  in  DATA_WIDTH  FIFO read data; valid the cycle after a rd_en cycle.
- fifo_rd_en  out  1  registered single-cycle pop request to FIFO.
- tx  out  1  serial output, idle high.
- busy  out  1  high in every state except IDLE.
- tx_done  out  1  single-cycle pulse on the cycle the stop bit completes.

## Operation
- Reset values: tx=1, fifo_rd_en=0, busy=0, tx_done=0, state=IDLE, counters=0, shift register=0.
- States: IDLE, POP, LOAD, START, DATA, STOP.
- IDLE: at an edge with en=1 and fifo_empty=0 → POP; otherwise stay.
- POP: fifo_rd_en=1 for exactly this one cycle; → LOAD unconditionally. fifo_rd_en is never high in two consecutive cycles, so the FIFO's registered flags settle before the next pop decision.
- LOAD: at the closing edge capture fifo_dout into shift register, set tx<=0, clear baud counter → START.
- START: tx=0 for CLKS_PER_BIT cycles → DATA with tx<=shift[0].
- DATA: each bit held CLKS_PER_BIT cycles; shift right on bit boundary; bit index 0..DATA_WIDTH-1; after bit DATA_WIDTH-1 → STOP with tx<=1.
- STOP: tx=1 for CLKS_PER_BIT cycles; tx_done pulses on the last STOP cycle; → IDLE.
- Baud counter width $clog2(CLKS_PER_BIT), counts 0..CLKS_PER_BIT-1, wraps to 0 on bit boundary; bit index width $clog2(DATA_WIDTH) (min 1).
- en deasserted mid-frame: frame completes; block then waits in IDLE.
- FIFO empty while IDLE: tx stays high, no rd_en issued.
- Reset mid-frame: tx returns high immediately (async), state IDLE; in-flight byte discarded, not re-fetched.

## Timing
- fifo_empty=0 sampled in IDLE at edge E0: fifo_rd_en high E0→E1, data captured at E2, tx falls at E2.
- Frame length: (DATA_WIDTH+2)×CLKS_PER_BIT cycles from tx falling edge to return to IDLE.
- Back-to-back bytes: tx high for CLKS_PER_BIT+3 cycles between frames (stop bit + IDLE, POP, LOAD).
- Maximum throughput: one FIFO pop per (DATA_WIDTH+2)×CLKS_PER_BIT+3 cycles.
- tx, fifo_rd_en, busy, tx_done all registered; no combinational path from inputs to outputs.

## Structure
- Shared package fifo_uart_pkg: state enum (IDLE, POP, LOAD, START, DATA, STOP), default CLKS_PER_BIT constant, frame-length helper function.
- One sub-module: fifo_uart_baud_tick — CLKS_PER_BIT counter with synchronous clear, outputs one-cycle bit-boundary tick; everything else in the top FSM.

## Test plan
- Reset: assert rst mid-DATA with CLKS_PER_BIT=4 → tx=1, busy=0, fifo_rd_en=0 same cycle; no pop after release while fifo_empty=1.
- Single byte: push 0xA5 into FIFO, en=1, CLKS_PER_BIT=4 → one rd_en pulse, tx sequence 0,1,0,1,0,0,1,0,1,1 each held 4 cycles, tx_done pulse on last stop cycle.
- Burst: push 0x00,0xFF,0x3C → exactly 3 rd_en pulses, never adjacent; 3 frames decode correctly; inter-frame tx high = 7 cycles.
- Enable gating: FIFO holds 2 bytes, drop en during first frame's DATA → first frame completes, no second rd_en until en returns high.
- Empty boundary: FIFO with one byte, concurrent write of 0x11 during first frame → second byte popped only after first stop bit, no pop while fifo_empty=1.
- Latency: fifo_empty falls at edge E0 in IDLE → fifo_rd_en high E0–E1, tx low from E2 exactly.

Source files
------------

// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        START,
        DATA,
        STOP
    } state_t;

    localparam int unsigned DEFAULT_DATA_WIDTH   = 8;
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;

    // Cycles from the falling start edge until the line is back in IDLE.
    function automatic int unsigned frame_cycles(input int unsigned data_width,
                                                 input int unsigned clks_per_bit);
        return (data_width + 2) * clks_per_bit;
    endfunction

endpackage

// File: rtl/fifo_uart_baud_tick.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1, synchronous clear, one-cycle tick on the last count.
module fifo_uart_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    output logic o_tick,
    output logic o_pre_tick
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_last;

    assign w_at_last = (r_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear || w_at_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Pre-tick lets the parent register a pulse that lines up with the tick cycle.
    assign o_tick     = !i_clear && w_at_last;
    assign o_pre_tick = !i_clear && (r_cnt == CNT_PRE);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains bytes from a synchronous FIFO and shifts them out as start/data/stop UART frames.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic [IDX_W-1:0]      r_bit_idx;
    logic                  r_tx;
    logic                  r_rd_en;
    logic                  r_busy;
    logic                  r_tx_done;
    logic                  w_clear;
    logic                  w_tick;
    logic                  w_pre_tick;
    logic                  w_bit_last;

    // Counter only runs while a bit is on the line; LOAD clears it for START.
    assign w_clear     = !(r_state inside {START, DATA, STOP});
    assign w_bit_last  = (r_bit_idx == IDX_LAST);
    assign w_shift_nxt = r_shift >> 1;

    fifo_uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_clear),
        .o_tick    (w_tick),
        .o_pre_tick(w_pre_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (en && !fifo_empty) w_state_nxt = POP;
            POP:     w_state_nxt = LOAD;
            LOAD:    w_state_nxt = START;
            START:   if (w_tick) w_state_nxt = DATA;
            DATA:    if (w_tick && w_bit_last) w_state_nxt = STOP;
            STOP:    if (w_tick) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_tx      <= 1'b1;
            r_rd_en   <= 1'b0;
            r_busy    <= 1'b0;
            r_tx_done <= 1'b0;
        end else begin
            r_rd_en   <= (w_state_nxt == POP);
            r_busy    <= (w_state_nxt != IDLE);
            r_tx_done <= (r_state == STOP) && w_pre_tick;
            case (r_state)
                LOAD: begin
                    r_shift   <= fifo_dout;
                    r_bit_idx <= '0;
                    r_tx      <= 1'b0;
                end
                START: begin
                    if (w_tick) r_tx <= r_shift[0];
                end
                DATA: begin
                    if (w_tick) begin
                        if (w_bit_last) begin
                            r_tx <= 1'b1;
                        end else begin
                            r_shift   <= w_shift_nxt;
                            r_tx      <= w_shift_nxt[0];
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign fifo_rd_en = r_rd_en;
    assign tx         = r_tx;
    assign busy       = r_busy;
    assign tx_done    = r_tx_done;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Randomised and directed bench for fifo_uart_tx against a frame-timeline model.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

    localparam int DW    = 8;
    localparam int CPB   = 4;
    localparam int FRAME = (DW + 2) * CPB;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_dout = '0;
    logic          fifo_rd_en;
    logic          tx;
    logic          busy;
    logic          tx_done;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;

    always #5 clk = ~clk;

    fifo_uart_tx #(
        .DATA_WIDTH  (DW),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .fifo_empty(fifo_empty),
        .fifo_dout (fifo_dout),
        .fifo_rd_en(fifo_rd_en),
        .tx        (tx),
        .busy      (busy),
        .tx_done   (tx_done)
    );

    // Upstream synchronous FIFO: registered data and empty flag, never reset.
    logic [DW-1:0] fq[$];
    always @(posedge clk) begin
        if (fifo_rd_en && fq.size() > 0) fifo_dout <= fq.pop_front();
        if (wr_en) fq.push_back(wr_data);
        fifo_empty <= (fq.size() == 0);
    end

    // Model: a frame is a timeline of cycles k = 0 (pop), 1 (load), 2.. (serial bits).
    logic          m_act = 1'b0;
    int            m_k = 0;
    logic [DW-1:0] m_byte = '0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_act <= 1'b0;
            m_k   <= 0;
        end else if (m_act) begin
            if (m_k == FRAME + 1) m_act <= 1'b0;
            m_k <= m_k + 1;
        end else if (en && !fifo_empty && fq.size() > 0) begin
            m_act  <= 1'b1;
            m_k    <= 0;
            m_byte <= fq[0];
        end
    end

    function automatic logic exp_tx_f(input logic act, input int k, input logic [DW-1:0] b);
        int bit_n;
        if (!act || k < 2) return 1'b1;
        bit_n = (k - 2) / CPB;
        if (bit_n == 0) return 1'b0;
        if (bit_n <= DW) return b[bit_n - 1];
        return 1'b1;
    endfunction

    int          n_cmp = 0;
    int          n_bad = 0;
    string       cq_name[$];
    logic [31:0] cq_act[$];
    logic [31:0] cq_exp[$];

    task automatic cmp(input string n, input logic [31:0] a, input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
        end
    endtask

    task automatic post(input string n, input logic [31:0] a, input logic [31:0] e);
        cq_name.push_back(n);
        cq_act.push_back(a);
        cq_exp.push_back(e);
    endtask

    // Single compare process: per-cycle model check plus queued directed checks.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            cmp("tx", {31'd0, tx}, {31'd0, exp_tx_f(m_act, m_k, m_byte)});
            cmp("busy", {31'd0, busy}, {31'd0, m_act});
            cmp("rd_en", {31'd0, fifo_rd_en}, {31'd0, m_act && m_k == 0});
            cmp("tx_done", {31'd0, tx_done}, {31'd0, m_act && m_k == FRAME + 1});
            while (cq_name.size() > 0)
                cmp(cq_name.pop_front(), cq_act.pop_front(), cq_exp.pop_front());
        end
    end

    task automatic push_byte(input logic [DW-1:0] b);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = b;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_rd(input int limit, output int waited, output bit seen);
        seen   = 1'b0;
        waited = 0;
        while (!seen && waited < limit) begin
            @(negedge clk);
            waited++;
            if (fifo_rd_en) seen = 1'b1;
        end
    endtask

    task automatic wait_idle(input int limit, output bit ok);
        int c;
        ok = 1'b0;
        c  = 0;
        while (!ok && c < limit) begin
            @(negedge clk);
            c++;
            if (!busy && fq.size() == 0 && fifo_empty) ok = 1'b1;
        end
    endtask

    int mon_rd[$];
    int mon_dn[$];
    int mon_adj;
    int mon_rd_empty;

    task automatic monitor(input int ncyc);
        bit prev;
        prev = 1'b0;
        mon_rd.delete();
        mon_dn.delete();
        mon_adj      = 0;
        mon_rd_empty = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (fifo_rd_en) begin
                mon_rd.push_back(c);
                if (prev) mon_adj++;
                if (fifo_empty) mon_rd_empty++;
            end
            prev = fifo_rd_en;
            if (tx_done) mon_dn.push_back(c);
        end
    endtask

    int         w;
    bit         seen;
    bit         ok;
    logic [9:0] seq;
    int         ndone;
    int         done_k;
    int         nrd;

    initial begin
        #1 rst = 1'b1;
        @(negedge clk);
        post("reset_tx", {31'd0, tx}, 32'd1);
        post("reset_busy", {31'd0, busy}, 32'd0);
        post("reset_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        post("reset_done", {31'd0, tx_done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;
        repeat (3) @(negedge clk);

        // Single byte 0xA5 with exact latency.
        push_byte(8'hA5);
        wait_rd(10, w, seen);
        post("lat_rd_seen", {31'd0, seen}, 32'd1);
        post("lat_rd_edge", w, 32'd1);
        @(negedge clk);
        post("load_tx_high", {31'd0, tx}, 32'd1);
        post("load_rd_low", {31'd0, fifo_rd_en}, 32'd0);
        seq    = '0;
        ndone  = 0;
        done_k = -1;
        nrd    = 0;
        for (int k = 2; k < 2 + FRAME; k++) begin
            @(negedge clk);
            if (k == 2) post("start_tx_low", {31'd0, tx}, 32'd0);
            if (((k - 2) % CPB) == 1) seq[(k - 2) / CPB] = tx;
            if (tx_done) begin
                ndone++;
                done_k = k;
            end
            if (fifo_rd_en) nrd++;
        end
        post("a5_bits", {22'd0, seq}, {22'd0, 10'b1101001010});
        post("a5_done_cnt", ndone, 32'd1);
        post("a5_done_k", done_k, 32'd41);
        post("a5_extra_rd", nrd, 32'd0);
        @(negedge clk);
        post("a5_idle_busy", {31'd0, busy}, 32'd0);
        post("a5_idle_tx", {31'd0, tx}, 32'd1);
        wait_idle(200, ok);
        post("a5_idle", {31'd0, ok}, 32'd1);

        // Burst of three bytes.
        fork
            begin
                push_byte(8'h00);
                push_byte(8'hFF);
                push_byte(8'h3C);
            end
            monitor(200);
        join
        post("burst_rd_cnt", mon_rd.size(), 32'd3);
        post("burst_done_cnt", mon_dn.size(), 32'd3);
        post("burst_adjacent", mon_adj, 32'd0);
        if (mon_rd.size() >= 3 && mon_dn.size() >= 2) begin
            post("burst_gap12", (mon_rd[1] + 2) - (mon_dn[0] - CPB + 1), 32'd7);
            post("burst_gap23", (mon_rd[2] + 2) - (mon_dn[1] - CPB + 1), 32'd7);
        end
        wait_idle(200, ok);
        post("burst_idle", {31'd0, ok}, 32'd1);

        // Enable dropped during the first frame's data bits.
        fork
            begin
                push_byte(8'h5A);
                push_byte(8'hC3);
            end
            monitor(14);
        join
        post("en_first_rd", mon_rd.size(), 32'd1);
        post("en_busy_at_drop", {31'd0, busy}, 32'd1);
        en = 1'b0;
        monitor(2 * FRAME);
        post("en_low_no_rd", mon_rd.size(), 32'd0);
        post("en_low_done", mon_dn.size(), 32'd1);
        post("en_low_busy", {31'd0, busy}, 32'd0);
        post("en_low_tx", {31'd0, tx}, 32'd1);
        en = 1'b1;
        wait_rd(10, w, seen);
        post("en_resume_rd", {31'd0, seen}, 32'd1);
        wait_idle(200, ok);
        post("en_idle", {31'd0, ok}, 32'd1);

        // Second byte written while the first is on the line.
        fork
            begin
                push_byte(8'h42);
                repeat (5) @(negedge clk);
                push_byte(8'h11);
            end
            monitor(2 * (FRAME + 4) + 20);
        join
        post("empty_rd_cnt", mon_rd.size(), 32'd2);
        post("empty_rd_while_empty", mon_rd_empty, 32'd0);
        if (mon_rd.size() >= 2 && mon_dn.size() >= 1)
            post("empty_second_pop", mon_rd[1] - mon_dn[0], 32'd2);
        wait_idle(200, ok);
        post("empty_idle", {31'd0, ok}, 32'd1);

        // Asynchronous reset in the middle of the data bits.
        push_byte(8'h96);
        wait_rd(10, w, seen);
        post("rst_frame_rd", {31'd0, seen}, 32'd1);
        repeat (12) @(negedge clk);
        post("rst_pre_tx_busy", {31'd0, busy}, 32'd1);
        #3 rst = 1'b1;
        #1;
        post("rst_async_tx", {31'd0, tx}, 32'd1);
        post("rst_async_busy", {31'd0, busy}, 32'd0);
        post("rst_async_rd", {31'd0, fifo_rd_en}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        monitor(30);
        post("rst_no_refetch", mon_rd.size(), 32'd0);
        post("rst_tx_idle", {31'd0, tx}, 32'd1);

        // Random traffic, enable toggling and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            wr_en   = ($urandom_range(0, 29) == 0);
            wr_data = DW'($urandom);
            if ($urandom_range(0, 149) == 0) en = ~en;
            rst = ($urandom_range(0, 999) == 0);
        end
        @(negedge clk);
        wr_en = 1'b0;
        rst   = 1'b0;
        en    = 1'b1;
        wait_idle(20000, ok);
        post("random_drain", {31'd0, ok}, 32'd1);

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
